cnt_bus_seq: RTL and testbench

- Command-driven sequencer for a bank of NUM_CNT 8-bit up/down counters that share one tri-state 8-bit data bus.
- Accepts one command per handshake and generates each counter's set/enable/direction/oe strobes.
- Owns bus turnaround, so only one driver is ever on the bus and a dead cycle separates drivers.
- Sits between the control unit and the counter bank.

---
 rtl/cnt_bus_seq_pkg.sv | 35 +++
 rtl/cnt_bus_seq_if.sv | 39 +++
 rtl/cnt_bus_seq_onehot_dec.sv | 23 ++
 rtl/cnt_bus_seq.sv | 184 ++++++++++++++++++
 tb/tb_cnt_bus_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_bus_seq_pkg.sv
// Shared encodings for the counter-bank bus sequencer: command opcodes,
// FSM states and the tag that records which agent last drove the shared bus.
package cnt_bus_pkg;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_READ = 2'd3
    } op_t;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_LOAD,
        ST_STEP,
        ST_RD_OE,
        ST_RD_CAP
    } state_t;

    // Bus-driver tag: nobody yet, the sequencer itself, or counter i (base + i)
    typedef logic [3:0] drv_t;

    localparam drv_t DRV_NONE     = 4'd0;
    localparam drv_t DRV_SEQ      = 4'd1;
    localparam drv_t DRV_CNT_BASE = 4'd2;

    // Tag for counter idx as a bus driver
    function automatic drv_t drv_cnt(input logic [3:0] idx);
        return DRV_CNT_BASE + idx;
    endfunction

endpackage

// File: rtl/cnt_bus_seq_if.sv
// Command, strobe and shared-bus signals between the control unit, the
// sequencer and the counter bank. The sequencer is the slave of the command
// side and owns all strobes; the environment uses the master view.
interface cnt_bus_seq_if
    import cnt_bus_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int SEL_W   = 2
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    op_t                cmd_op;
    logic [SEL_W-1:0]   cmd_sel;
    logic [7:0]         cmd_data;
    logic [NUM_CNT-1:0] cnt_set;
    logic [NUM_CNT-1:0] cnt_en;
    logic               cnt_down;
    logic [NUM_CNT-1:0] cnt_oe;
    logic               bus_drive;
    logic [7:0]         bus_out;
    logic [7:0]         bus_in;
    logic               rsp_valid;
    logic [7:0]         rsp_data;
    logic               err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data, bus_in,
        output cmd_ready, cnt_set, cnt_en, cnt_down, cnt_oe,
               bus_drive, bus_out, rsp_valid, rsp_data, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data, bus_in,
        input  cmd_ready, cnt_set, cnt_en, cnt_down, cnt_oe,
               bus_drive, bus_out, rsp_valid, rsp_data, err
    );

endinterface

// File: rtl/cnt_bus_seq_onehot_dec.sv
// Select-to-one-hot decoder with enable; used for the per-counter
// set, enable and output-enable strobe vectors.
module cnt_onehot_dec #(
    parameter int SEL_W   = 2,
    parameter int NUM_CNT = 4
) (
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               en_i,
    output logic [NUM_CNT-1:0] onehot_o
);

    // Raise the single bit addressed by sel_i when enabled
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot_o = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_bus_seq.sv
// Command sequencer for a bank of 8-bit up/down counters sharing one bus.
// Accepts one command at a time, generates registered set/en/oe strobes and
// inserts a dead cycle whenever bus ownership changes hands.
module cnt_bus_seq
    import cnt_bus_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int SEL_W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    cnt_bus_seq_if.slave bus
);

    state_t             state_q,     state_d;
    op_t                op_q,        op_d;
    logic [SEL_W-1:0]   sel_q,       sel_d;
    logic [7:0]         data_q,      data_d;      // LOAD value, or steps remaining
    drv_t               last_drv_q,  last_drv_d;
    logic [7:0]         rsp_data_q,  rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               err_q,       err_d;
    logic               bus_drive_q, bus_drive_d;
    logic [7:0]         bus_out_q,   bus_out_d;
    logic               cnt_down_q,  cnt_down_d;
    logic [NUM_CNT-1:0] cnt_set_q,   cnt_set_d;
    logic [NUM_CNT-1:0] cnt_en_q,    cnt_en_d;
    logic [NUM_CNT-1:0] cnt_oe_q,    cnt_oe_d;

    logic set_on, en_on, oe_on;
    logic sel_ok, need_turn;
    drv_t req_drv;

    // Legality of the offered select and whether its bus owner differs from the last one
    always_comb begin
        sel_ok = 32'(bus.cmd_sel) < NUM_CNT;
        case (bus.cmd_op)
            OP_LOAD: req_drv = DRV_SEQ;
            OP_READ: req_drv = drv_cnt(4'(bus.cmd_sel));
            default: req_drv = last_drv_q;   // UP/DOWN never touch the bus
        endcase
        need_turn = (last_drv_q != DRV_NONE) && (last_drv_q != req_drv);
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sel_d       = sel_q;
        data_d      = data_q;
        last_drv_d  = last_drv_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high throughout IDLE while out of reset, so valid alone accepts
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    sel_d  = bus.cmd_sel;
                    data_d = bus.cmd_data;
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        case (bus.cmd_op)
                            OP_LOAD: state_d = need_turn ? ST_TURN : ST_LOAD;
                            OP_READ: state_d = need_turn ? ST_TURN : ST_RD_OE;
                            default: state_d = ST_STEP;
                        endcase
                    end
                end
            end
            ST_TURN: begin
                state_d = (op_q == OP_LOAD) ? ST_LOAD : ST_RD_OE;
            end
            ST_LOAD: begin
                state_d    = ST_IDLE;
                last_drv_d = DRV_SEQ;
            end
            ST_STEP: begin
                if (data_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
                if (data_q != 8'd0) begin
                    data_d = data_q - 8'd1;
                end
            end
            ST_RD_OE: begin
                // The addressed counter has been driving the bus for this whole cycle
                state_d     = ST_RD_CAP;
                rsp_data_d  = bus.bus_in;
                rsp_valid_d = 1'b1;
            end
            ST_RD_CAP: begin
                state_d    = ST_IDLE;
                last_drv_d = drv_cnt(4'(sel_q));
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        set_on      = (state_d == ST_LOAD);
        en_on       = (state_d == ST_STEP) && (data_d != 8'd0);
        oe_on       = (state_d == ST_RD_OE) || (state_d == ST_RD_CAP);
        bus_drive_d = set_on;
        bus_out_d   = set_on ? data_d : 8'h00;
        cnt_down_d  = (state_d == ST_STEP) && (op_d == OP_DOWN);
    end

    cnt_onehot_dec #(.SEL_W(SEL_W), .NUM_CNT(NUM_CNT)) u_set_dec (
        .sel_i    (sel_d),
        .en_i     (set_on),
        .onehot_o (cnt_set_d)
    );

    cnt_onehot_dec #(.SEL_W(SEL_W), .NUM_CNT(NUM_CNT)) u_en_dec (
        .sel_i    (sel_d),
        .en_i     (en_on),
        .onehot_o (cnt_en_d)
    );

    cnt_onehot_dec #(.SEL_W(SEL_W), .NUM_CNT(NUM_CNT)) u_oe_dec (
        .sel_i    (sel_d),
        .en_i     (oe_on),
        .onehot_o (cnt_oe_d)
    );

    // State, captured command and registered outputs; reset drops every strobe at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            sel_q       <= '0;
            data_q      <= 8'h00;
            last_drv_q  <= DRV_NONE;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            bus_drive_q <= 1'b0;
            bus_out_q   <= 8'h00;
            cnt_down_q  <= 1'b0;
            cnt_set_q   <= '0;
            cnt_en_q    <= '0;
            cnt_oe_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            last_drv_q  <= last_drv_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            bus_drive_q <= bus_drive_d;
            bus_out_q   <= bus_out_d;
            cnt_down_q  <= cnt_down_d;
            cnt_set_q   <= cnt_set_d;
            cnt_en_q    <= cnt_en_d;
            cnt_oe_q    <= cnt_oe_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
    assign bus.cnt_set   = cnt_set_q;
    assign bus.cnt_en    = cnt_en_q;
    assign bus.cnt_down  = cnt_down_q;
    assign bus.cnt_oe    = cnt_oe_q;
    assign bus.bus_drive = bus_drive_q;
    assign bus.bus_out   = bus_out_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err       = err_q;

    // Single bus owner and well-formed strobe vectors
    a_oe_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(cnt_oe_q));
    a_oe_vs_drive: assert property (@(posedge clk) disable iff (reset) !(bus_drive_q && (|cnt_oe_q)));
    a_set_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(cnt_set_q));
    a_en_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(cnt_en_q));
    a_set_vs_en:   assert property (@(posedge clk) disable iff (reset) !((|cnt_set_q) && (|cnt_en_q)));

endmodule

// File: tb/tb_cnt_bus_seq.sv
// Bench for cnt_bus_seq: a behavioural counter bank on a resolved bus,
// a directed vector table, a reset-during-STEP sequence and random commands
// checked against a transaction-level model.
module tb_cnt_bus_seq;
    import cnt_bus_pkg::*;

    localparam int NUM_CNT = 4;
    localparam int SEL_W   = 3;
    localparam int M_NONE  = -2;   // model: no driver yet
    localparam int M_SEQ   = -1;   // model: sequencer drove last; >= 0 means counter index

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cnt_bus_seq_if #(.NUM_CNT(NUM_CNT), .SEL_W(SEL_W)) dut_if ();

    cnt_bus_seq #(.NUM_CNT(NUM_CNT), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    // Counter bank hardware that the sequencer controls
    logic [7:0] bank [NUM_CNT];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) bank[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (dut_if.cnt_set[i])     bank[i] <= dut_if.bus_in;
                else if (dut_if.cnt_en[i]) bank[i] <= dut_if.cnt_down ? bank[i] - 8'd1 : bank[i] + 8'd1;
            end
        end
    end

    // Resolved bus: pulled high when nobody drives
    always_comb begin
        dut_if.bus_in = 8'hFF;
        if (dut_if.bus_drive) dut_if.bus_in = dut_if.bus_out;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (dut_if.cnt_oe[i]) dut_if.bus_in = bank[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // What was observed for one command, from the cycle after acceptance until ready returns
    typedef struct {
        int                 busy;
        int                 quiet;
        int                 set_cyc;
        int                 en_cyc;
        int                 oe_cyc;
        int                 down_hi;
        int                 err_cnt;
        int                 rsp_cnt;
        int                 rsp_cyc;
        int                 viol;
        logic [7:0]         rsp_val;
        logic [7:0]         bus_val;
        logic [NUM_CNT-1:0] set_vec;
        logic [NUM_CNT-1:0] en_vec;
        logic [NUM_CNT-1:0] oe_vec;
        bit                 timeout;
    } res_t;

    task automatic do_cmd(input op_t op, input logic [SEL_W-1:0] sel, input logic [7:0] data,
                          output res_t r);
        int k;
        logic [NUM_CNT-1:0] s, e, o;
        r = '{default: 0};
        @(negedge clk);
        dut_if.cmd_valid = 1'b1;
        dut_if.cmd_op    = op;
        dut_if.cmd_sel   = sel;
        dut_if.cmd_data  = data;
        k = 0;
        while (!dut_if.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!dut_if.cmd_ready) begin
            r.timeout = 1'b1;
            dut_if.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        dut_if.cmd_valid = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            s = dut_if.cnt_set;
            e = dut_if.cnt_en;
            o = dut_if.cnt_oe;
            if (!dut_if.cmd_ready) begin
                r.busy++;
                if (s == '0 && e == '0 && o == '0 && !dut_if.bus_drive) r.quiet++;
            end
            if (s != '0) begin
                r.set_cyc++;
                r.set_vec |= s;
                r.bus_val = dut_if.bus_out;
            end
            if (e != '0) begin
                r.en_cyc++;
                r.en_vec |= e;
                if (dut_if.cnt_down) r.down_hi++;
            end
            if (o != '0) begin
                r.oe_cyc++;
                r.oe_vec |= o;
            end
            if ($countones(s) > 1 || $countones(e) > 1 || $countones(o) > 1 ||
                (s != '0 && e != '0) || (o != '0 && dut_if.bus_drive) ||
                (dut_if.bus_drive != (s != '0))) r.viol++;
            if (dut_if.err) r.err_cnt++;
            if (dut_if.rsp_valid) begin
                r.rsp_cnt++;
                r.rsp_cyc = c;
                r.rsp_val = dut_if.rsp_data;
            end
            if (dut_if.cmd_ready) return;
            @(negedge clk);
        end
        r.timeout = 1'b1;
    endtask

    // Transaction-level reference state
    logic [7:0] m_cnt [NUM_CNT];
    int         m_last;
    logic [7:0] m_rsp;

    task automatic model_reset();
        for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 8'h00;
        m_last = M_NONE;
        m_rsp  = 8'h00;
    endtask

    // Predict the whole command from the rules, compare, then advance the model
    task automatic expect_cmd(input string tag, input op_t op, input int sel,
                              input logic [7:0] data, input res_t r);
        int e_busy, e_quiet, e_set, e_en, e_oe, e_down, e_err, e_rsp, e_rsp_cyc;
        logic [NUM_CNT-1:0] e_set_vec, e_en_vec, e_oe_vec;
        logic [7:0] e_bus, e_rsp_val;
        bit turn;
        e_busy = 0; e_quiet = 0; e_set = 0; e_en = 0; e_oe = 0; e_down = 0;
        e_err = 0; e_rsp = 0; e_rsp_cyc = 0;
        e_set_vec = '0; e_en_vec = '0; e_oe_vec = '0;
        e_bus = 8'h00; e_rsp_val = 8'h00;
        check({tag, " timeout"}, 32'(r.timeout), 0);
        if (sel >= NUM_CNT) begin
            e_err = 1;
        end else begin
            case (op)
                OP_LOAD: begin
                    turn      = (m_last != M_NONE) && (m_last != M_SEQ);
                    e_busy    = 1 + int'(turn);
                    e_quiet   = int'(turn);
                    e_set     = 1;
                    e_set_vec = NUM_CNT'(1) << sel;
                    e_bus     = data;
                    m_cnt[sel] = data;
                    m_last    = M_SEQ;
                end
                OP_READ: begin
                    turn      = (m_last != M_NONE) && (m_last != sel);
                    e_busy    = 2 + int'(turn);
                    e_quiet   = int'(turn);
                    e_oe      = 2;
                    e_oe_vec  = NUM_CNT'(1) << sel;
                    e_rsp     = 1;
                    e_rsp_cyc = 2 + int'(turn);
                    e_rsp_val = m_cnt[sel];
                    m_rsp     = m_cnt[sel];
                    m_last    = sel;
                end
                default: begin
                    e_busy   = (data == 8'd0) ? 1 : int'(data);
                    e_quiet  = (data == 8'd0) ? 1 : 0;
                    e_en     = int'(data);
                    e_en_vec = (data == 8'd0) ? '0 : NUM_CNT'(1) << sel;
                    e_down   = (op == OP_DOWN) ? int'(data) : 0;
                    m_cnt[sel] = (op == OP_UP) ? m_cnt[sel] + data : m_cnt[sel] - data;
                end
            endcase
        end
        check({tag, " busy"},     r.busy,     e_busy);
        check({tag, " quiet"},    r.quiet,    e_quiet);
        check({tag, " err"},      r.err_cnt,  e_err);
        check({tag, " rsp_cnt"},  r.rsp_cnt,  e_rsp);
        check({tag, " set_cyc"},  r.set_cyc,  e_set);
        check({tag, " en_cyc"},   r.en_cyc,   e_en);
        check({tag, " oe_cyc"},   r.oe_cyc,   e_oe);
        check({tag, " set_vec"},  32'(r.set_vec), 32'(e_set_vec));
        check({tag, " en_vec"},   32'(r.en_vec),  32'(e_en_vec));
        check({tag, " oe_vec"},   32'(r.oe_vec),  32'(e_oe_vec));
        check({tag, " down"},     r.down_hi,  e_down);
        check({tag, " invariant"}, r.viol,    0);
        if (e_rsp != 0) begin
            check({tag, " rsp_cyc"}, r.rsp_cyc, e_rsp_cyc);
            check({tag, " rsp_val"}, 32'(r.rsp_val), 32'(e_rsp_val));
        end
        if (e_set != 0) check({tag, " bus_out"}, 32'(r.bus_val), 32'(e_bus));
        check({tag, " rsp_hold"}, 32'(dut_if.rsp_data), 32'(m_rsp));
        for (int i = 0; i < NUM_CNT; i++) begin
            check($sformatf("%s bank%0d", tag, i), 32'(bank[i]), 32'(m_cnt[i]));
        end
    endtask

    // Directed vectors with hand-derived expectations (bank starts at zero)
    typedef struct {
        op_t              op;
        logic [SEL_W-1:0] sel;
        logic [7:0]       data;
        int               exp_busy;
        int               exp_quiet;
        int               exp_err;
        int               exp_rsp_cyc;   // 0 = no response
        logic [7:0]       exp_rsp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int rsp_seen, err_seen, k;
        op_t rop;
        logic [SEL_W-1:0] rsel;
        logic [7:0] rdata;

        vecs[0]  = '{OP_LOAD, 3'd1, 8'hA5, 1, 0, 0, 0, 8'h00};
        vecs[1]  = '{OP_READ, 3'd1, 8'h00, 3, 1, 0, 3, 8'hA5};
        vecs[2]  = '{OP_LOAD, 3'd2, 8'hFE, 2, 1, 0, 0, 8'h00};
        vecs[3]  = '{OP_UP,   3'd2, 8'd3,  3, 0, 0, 0, 8'h00};
        vecs[4]  = '{OP_READ, 3'd2, 8'h00, 3, 1, 0, 3, 8'h01};
        vecs[5]  = '{OP_DOWN, 3'd0, 8'd0,  1, 1, 0, 0, 8'h00};
        vecs[6]  = '{OP_UP,   3'd5, 8'd7,  0, 0, 1, 0, 8'h00};
        vecs[7]  = '{OP_READ, 3'd2, 8'h00, 2, 0, 0, 2, 8'h01};
        vecs[8]  = '{OP_READ, 3'd0, 8'h00, 3, 1, 0, 3, 8'h00};
        vecs[9]  = '{OP_DOWN, 3'd0, 8'd2,  2, 0, 0, 0, 8'h00};
        vecs[10] = '{OP_READ, 3'd0, 8'h00, 2, 0, 0, 2, 8'hFE};
        vecs[11] = '{OP_LOAD, 3'd3, 8'h3C, 2, 1, 0, 0, 8'h00};
        vecs[12] = '{OP_LOAD, 3'd1, 8'h77, 1, 0, 0, 0, 8'h00};
        vecs[13] = '{OP_READ, 3'd3, 8'h00, 3, 1, 0, 3, 8'h3C};
        vecs[14] = '{OP_UP,   3'd1, 8'd2,  2, 0, 0, 0, 8'h00};
        vecs[15] = '{OP_READ, 3'd1, 8'h00, 3, 1, 0, 3, 8'h79};

        reset            = 1'b1;
        dut_if.cmd_valid = 1'b0;
        dut_if.cmd_op    = OP_LOAD;
        dut_if.cmd_sel   = '0;
        dut_if.cmd_data  = 8'h00;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset ready",   32'(dut_if.cmd_ready), 0);
        check("reset strobes", 32'({dut_if.cnt_set, dut_if.cnt_en, dut_if.cnt_oe}), 0);
        check("reset bus",     32'({dut_if.bus_drive, dut_if.bus_out, dut_if.cnt_down}), 0);
        check("reset rsp",     32'({dut_if.rsp_valid, dut_if.rsp_data, dut_if.err}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle ready", 32'(dut_if.cmd_ready), 1);

        for (int i = 0; i < 16; i++) begin
            do_cmd(vecs[i].op, vecs[i].sel, vecs[i].data, r);
            check($sformatf("vec%0d busy", i),  r.busy,    vecs[i].exp_busy);
            check($sformatf("vec%0d quiet", i), r.quiet,   vecs[i].exp_quiet);
            check($sformatf("vec%0d err", i),   r.err_cnt, vecs[i].exp_err);
            check($sformatf("vec%0d rsp_cnt", i), r.rsp_cnt, (vecs[i].exp_rsp_cyc != 0) ? 1 : 0);
            if (vecs[i].exp_rsp_cyc != 0) begin
                check($sformatf("vec%0d rsp_cyc", i), r.rsp_cyc, vecs[i].exp_rsp_cyc);
                check($sformatf("vec%0d rsp_val", i), 32'(r.rsp_val), 32'(vecs[i].exp_rsp));
            end
            expect_cmd($sformatf("vec%0d", i), vecs[i].op, int'(vecs[i].sel), vecs[i].data, r);
        end

        // Reset in the middle of a 10-step UP: strobes drop without a clock edge
        rsp_seen = 0;
        err_seen = 0;
        @(negedge clk);
        dut_if.cmd_valid = 1'b1;
        dut_if.cmd_op    = OP_UP;
        dut_if.cmd_sel   = 3'd1;
        dut_if.cmd_data  = 8'd10;
        k = 0;
        while (!dut_if.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst seq accept", 32'(dut_if.cmd_ready), 1);
        @(negedge clk);
        dut_if.cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            if (dut_if.rsp_valid) rsp_seen++;
            if (dut_if.err) err_seen++;
        end
        check("rst seq en before", 32'(dut_if.cnt_en), 32'(4'b0010));
        #2 reset = 1'b1;
        #1;
        check("rst seq en async", 32'(dut_if.cnt_en), 0);
        check("rst seq ready low", 32'(dut_if.cmd_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dut_if.rsp_valid) rsp_seen++;
            if (dut_if.err) err_seen++;
        end
        check("rst seq no rsp", rsp_seen, 0);
        check("rst seq no err", err_seen, 0);
        check("rst seq ready",  32'(dut_if.cmd_ready), 1);
        check("rst seq strobes", 32'({dut_if.cnt_set, dut_if.cnt_en, dut_if.cnt_oe}), 0);
        check("rst seq rsp_data", 32'(dut_if.rsp_data), 0);

        // Random commands against the transaction model
        for (int n = 0; n < 200; n++) begin
            rop  = op_t'($urandom_range(0, 3));
            rsel = ($urandom_range(0, 9) == 0) ? SEL_W'($urandom_range(4, 7))
                                               : SEL_W'($urandom_range(0, 3));
            if (rop == OP_UP || rop == OP_DOWN) begin
                rdata = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255))
                                                     : 8'($urandom_range(0, 9));
            end else begin
                rdata = 8'($urandom);
            end
            do_cmd(rop, rsel, rdata, r);
            expect_cmd($sformatf("rnd%0d", n), rop, int'(rsel), rdata, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
